// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared defaults and types for the memory arbiter slice.
//   - *_DEF localparams : default widths/depth used by mem_arbiter and
//                         wt_write_buffer parameter lists.
//   - BLK_LSB           : low bit of the cache-block index (16-byte blocks).
//   - arb_state_e       : arbiter FSM states.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 10;   // byte-address width
    localparam int LINE_W_DEF   = 128;  // cache block, 4 words
    localparam int WORD_W_DEF   = 32;   // write-through word
    localparam int WB_DEPTH_DEF = 4;    // write-buffer entries

    // A block is 16 bytes, so addr[ADDR_W-1:4] names the block.
    localparam int BLK_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IC = 2'd1,
        RD_DC = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/wt_write_buffer.sv
// -----------------------------------------------------------------------------
// wt_write_buffer
//   Write-through FIFO holding {address, word} pairs, plus a block-address
//   match against two query addresses so the arbiter can detect a read
//   that would bypass a buffered write to the same block.
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   push, push_addr/data   : enqueue request (ignored while full)
//   pop                    : dequeue oldest entry (ignored while empty)
//   query_a, query_b       : byte addresses compared by block index
//   match_a, match_b       : some valid entry shares the query's block
//   head_addr, head_data   : oldest entry
//   full, empty, count     : occupancy
// -----------------------------------------------------------------------------
module wt_write_buffer
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = WB_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [WORD_W-1:0]            push_data,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            query_a,
    input  logic [ADDR_W-1:0]            query_b,
    output logic                         match_a,
    output logic                         match_b,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [WORD_W-1:0]            head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [WORD_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Wrap explicitly so a non-power-of-two depth still works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                valid[wr_ptr]    <= 1'b1;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            // push_ok and pop_ok never target the same slot: a push needs a
            // free slot, a pop needs an occupied one.
            if (pop_ok) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr_mem[i][ADDR_W-1:BLK_LSB] == query_a[ADDR_W-1:BLK_LSB]))
                match_a = 1'b1;
            if (valid[i] && (addr_mem[i][ADDR_W-1:BLK_LSB] == query_b[ADDR_W-1:BLK_LSB]))
                match_b = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between an I-cache (block refills) and a D-cache
//   (block refills plus write-through words). D-cache writes are absorbed by
//   a write buffer and drained to memory in the background; reads are
//   arbitrated round-robin, but a read whose block is still sitting in the
//   buffer forces a drain first so it never returns stale data.
//
// Handshakes: a requester raises *_req with stable address/data and holds it
//   until its one-cycle *_done pulse; a request is not re-accepted in the
//   cycle its done is high. Toward memory, mem_req and its qualifiers are
//   registered, held stable until mem_ack is sampled, and mem_req drops for
//   at least one cycle between transactions.
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   ic_req/ic_addr              : I-cache refill request
//   ic_done/ic_rdata            : refill complete pulse + block
//   dc_req/dc_we/dc_addr/dc_wdata : D-cache refill (we=0) or word write (we=1)
//   dc_done/dc_rdata            : completion/acceptance pulse + refill block
//   mem_req/mem_we/mem_addr/mem_wdata : memory request
//   mem_ack/mem_rdata           : memory completion + read block
//   dbg_state                   : current FSM state (arb_state_e encoding)
//   dbg_wb_count                : write-buffer occupancy
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LINE_W   = LINE_W_DEF,
    parameter int WORD_W   = WORD_W_DEF,
    parameter int WB_DEPTH = WB_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic                          ic_done,
    output logic [LINE_W-1:0]             ic_rdata,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [WORD_W-1:0]             dc_wdata,
    output logic                          dc_done,
    output logic [LINE_W-1:0]             dc_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [WORD_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [LINE_W-1:0]             mem_rdata,
    output logic [1:0]                    dbg_state,
    output logic [$clog2(WB_DEPTH+1)-1:0] dbg_wb_count
);

    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    arb_state_e        state, state_next;
    logic              rr_dc, rr_dc_next;        // 1: DC wins the next contested grant
    logic              rr_flip, rr_flip_next;    // current read was a contested grant
    logic              mem_req_next, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [WORD_W-1:0] mem_wdata_next;
    logic              ic_done_next, dc_done_next;
    logic [LINE_W-1:0] ic_rdata_next, dc_rdata_next;

    logic              ic_pend, dc_rd_pend;
    logic              wb_push, wb_pop;
    logic              wb_full, wb_empty;
    logic              wb_match_ic, wb_match_dc;
    logic [ADDR_W-1:0] wb_head_addr;
    logic [WORD_W-1:0] wb_head_data;
    logic [CNT_W-1:0]  wb_count;
    logic              read_hit, push_hit;
    logic              go_ic, go_dc, go_drain, contested;
    logic [ADDR_W-1:0] ic_line_addr, dc_line_addr, drain_addr;

    // A request whose done is high this cycle has already been served.
    assign ic_pend    = ic_req & ~ic_done;
    assign dc_rd_pend = dc_req & ~dc_we & ~dc_done;
    assign wb_push    = dc_req & dc_we & ~dc_done & ~wb_full;

    assign ic_line_addr = {ic_addr[ADDR_W-1:BLK_LSB], {BLK_LSB{1'b0}}};
    assign dc_line_addr = {dc_addr[ADDR_W-1:BLK_LSB], {BLK_LSB{1'b0}}};
    assign drain_addr   = {wb_head_addr[ADDR_W-1:2], 2'b00};

    assign read_hit = (ic_pend & wb_match_ic) | (dc_rd_pend & wb_match_dc);
    // A write to the I-cache read's block is entering the buffer at this very
    // edge and is not yet visible to the match logic; hold the read one cycle
    // so it is seen and drained first. (A DC read cannot coincide with a push.)
    assign push_hit = wb_push & ic_pend &
                      (ic_addr[ADDR_W-1:BLK_LSB] == dc_addr[ADDR_W-1:BLK_LSB]);

    assign dbg_state    = state;
    assign dbg_wb_count = wb_count;

    wt_write_buffer #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W),
        .DEPTH  (WB_DEPTH)
    ) u_wb (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wb_push),
        .push_addr (dc_addr),
        .push_data (dc_wdata),
        .pop       (wb_pop),
        .query_a   (ic_addr),
        .query_b   (dc_addr),
        .match_a   (wb_match_ic),
        .match_b   (wb_match_dc),
        .head_addr (wb_head_addr),
        .head_data (wb_head_data),
        .full      (wb_full),
        .empty     (wb_empty),
        .count     (wb_count)
    );

    // IDLE selection, in priority order.
    always_comb begin
        go_ic     = 1'b0;
        go_dc     = 1'b0;
        go_drain  = 1'b0;
        contested = 1'b0;
        if (state == IDLE) begin
            if (wb_full || read_hit) begin
                go_drain = 1'b1;
            end else if (push_hit) begin
                go_ic = 1'b0;
            end else if (ic_pend && dc_rd_pend) begin
                contested = 1'b1;
                go_dc     = rr_dc;
                go_ic     = ~rr_dc;
            end else if (ic_pend) begin
                go_ic = 1'b1;
            end else if (dc_rd_pend) begin
                go_dc = 1'b1;
            end else if (!wb_empty) begin
                go_drain = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        rr_dc_next     = rr_dc;
        rr_flip_next   = rr_flip;
        mem_req_next   = mem_req;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        ic_done_next   = 1'b0;
        dc_done_next   = wb_push;       // write acceptance pulses next cycle
        ic_rdata_next  = ic_rdata;
        dc_rdata_next  = dc_rdata;
        wb_pop         = 1'b0;

        case (state)
            IDLE: begin
                if (go_ic) begin
                    state_next     = RD_IC;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = ic_line_addr;
                    mem_wdata_next = '0;
                    rr_flip_next   = contested;
                end else if (go_dc) begin
                    state_next     = RD_DC;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = dc_line_addr;
                    mem_wdata_next = '0;
                    rr_flip_next   = contested;
                end else if (go_drain) begin
                    state_next     = DRAIN;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b1;
                    mem_addr_next  = drain_addr;
                    mem_wdata_next = wb_head_data;
                end
            end
            RD_IC: begin
                if (mem_ack) begin
                    state_next    = IDLE;
                    mem_req_next  = 1'b0;
                    ic_done_next  = 1'b1;
                    ic_rdata_next = mem_rdata;
                    // Only a grant won through arbitration moves the pointer.
                    if (rr_flip) rr_dc_next = ~rr_dc;
                    rr_flip_next  = 1'b0;
                end
            end
            RD_DC: begin
                if (mem_ack) begin
                    state_next    = IDLE;
                    mem_req_next  = 1'b0;
                    dc_done_next  = 1'b1;
                    dc_rdata_next = mem_rdata;
                    if (rr_flip) rr_dc_next = ~rr_dc;
                    rr_flip_next  = 1'b0;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    wb_pop       = 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_dc     <= 1'b0;
            rr_flip   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ic_done   <= 1'b0;
            dc_done   <= 1'b0;
            ic_rdata  <= '0;
            dc_rdata  <= '0;
        end else begin
            state     <= state_next;
            rr_dc     <= rr_dc_next;
            rr_flip   <= rr_flip_next;
            mem_req   <= mem_req_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            ic_done   <= ic_done_next;
            dc_done   <= dc_done_next;
            ic_rdata  <= ic_rdata_next;
            dc_rdata  <= dc_rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter: single IC refill, round-robin read pairs,
//   write-buffer fill/stall, read-after-write drain ordering, and reset
//   during a transaction / with buffered writes.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         ic_req;
    logic [9:0]   ic_addr;
    logic         ic_done;
    logic [127:0] ic_rdata;
    logic         dc_req;
    logic         dc_we;
    logic [9:0]   dc_addr;
    logic [31:0]  dc_wdata;
    logic         dc_done;
    logic [127:0] dc_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [9:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [127:0] mem_rdata;
    logic [1:0]   dbg_state;
    logic [2:0]   dbg_wb_count;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ic_req       (ic_req),
        .ic_addr      (ic_addr),
        .ic_done      (ic_done),
        .ic_rdata     (ic_rdata),
        .dc_req       (dc_req),
        .dc_we        (dc_we),
        .dc_addr      (dc_addr),
        .dc_wdata     (dc_wdata),
        .dc_done      (dc_done),
        .dc_rdata     (dc_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .dbg_state    (dbg_state),
        .dbg_wb_count (dbg_wb_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (!mem_req && n < 20) begin
            cyc();
            n++;
        end
        check({tag, "_req"}, mem_req, 1'b1);
    endtask

    task automatic wait_dc_done(input string tag);
        int n = 0;
        cyc();
        while (!dc_done && n < 20) begin
            cyc();
            n++;
        end
        check({tag, "_done"}, dc_done, 1'b1);
    endtask

    // Memory model: wait for a request, check it, stall `delay` cycles while
    // checking stability, then ack for one cycle with `rd`.
    task automatic mem_serve(input string tag, input logic exp_we, input logic [9:0] exp_addr,
                             input logic [31:0] exp_wdata, input int delay, input logic [127:0] rd);
        logic bad = 1'b0;
        wait_mem_req(tag);
        check({tag, "_we"}, mem_we, exp_we);
        check({tag, "_addr"}, mem_addr, exp_addr);
        if (exp_we) check({tag, "_wdata"}, mem_wdata, exp_wdata);
        for (int i = 0; i < delay; i++) begin
            cyc();
            if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== exp_we) bad = 1'b1;
        end
        check({tag, "_hold"}, bad, 1'b0);
        mem_rdata = rd;
        mem_ack   = 1'b1;
        cyc();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check({tag, "_gap"}, mem_req, 1'b0);
    endtask

    task automatic dc_write(input string tag, input logic [9:0] a, input logic [31:0] d);
        dc_req   = 1'b1;
        dc_we    = 1'b1;
        dc_addr  = a;
        dc_wdata = d;
        wait_dc_done(tag);
        dc_req   = 1'b0;
        dc_we    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic saw;
        rst_n     = 1'b0;
        ic_req    = 1'b0;
        ic_addr   = '0;
        dc_req    = 1'b0;
        dc_we     = 1'b0;
        dc_addr   = '0;
        dc_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) cyc();

        check("rst_state", dbg_state, 2'd0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_ic_rdata", ic_rdata, 128'h0);
        check("rst_dc_done", dc_done, 1'b0);
        check("rst_wb_count", dbg_wb_count, 3'd0);
        rst_n = 1'b1;
        cyc();

        // --- single IC refill ---
        ic_req  = 1'b1;
        ic_addr = 10'h1A4;
        mem_serve("ic1", 1'b0, 10'h1A0, 32'h0, 3, 128'h0123_4567_89AB_CDEF_0011_2233_4455_C0DE);
        check("ic1_done", ic_done, 1'b1);
        check("ic1_rdata", ic_rdata, 128'h0123_4567_89AB_CDEF_0011_2233_4455_C0DE);
        check("ic1_dc_done", dc_done, 1'b0);
        ic_req = 1'b0;
        cyc();
        check("ic1_pulse", ic_done, 1'b0);

        // --- round-robin: first pair IC first, second pair DC first ---
        ic_req  = 1'b1; ic_addr = 10'h040;
        dc_req  = 1'b1; dc_we = 1'b0; dc_addr = 10'h08C;
        mem_serve("rr1a", 1'b0, 10'h040, 32'h0, 1, 128'h1111);
        check("rr1a_ic_done", ic_done, 1'b1);
        check("rr1a_dc_done", dc_done, 1'b0);
        ic_req = 1'b0;
        mem_serve("rr1b", 1'b0, 10'h080, 32'h0, 1, 128'h2222);
        check("rr1b_dc_done", dc_done, 1'b1);
        check("rr1b_dc_rdata", dc_rdata, 128'h2222);
        dc_req = 1'b0;
        cyc();
        ic_req  = 1'b1; ic_addr = 10'h100;
        dc_req  = 1'b1; dc_we = 1'b0; dc_addr = 10'h200;
        mem_serve("rr2a", 1'b0, 10'h200, 32'h0, 1, 128'h3333);
        check("rr2a_dc_done", dc_done, 1'b1);
        check("rr2a_ic_done", ic_done, 1'b0);
        dc_req = 1'b0;
        mem_serve("rr2b", 1'b0, 10'h100, 32'h0, 1, 128'h4444);
        check("rr2b_ic_done", ic_done, 1'b1);
        check("rr2b_ic_rdata", ic_rdata, 128'h4444);
        ic_req = 1'b0;
        cyc();

        // --- five writes with memory stalled ---
        for (int k = 0; k < 4; k++) begin
            dc_write($sformatf("wr%0d", k), 10'h300 + 10'(k * 4), 32'hA000_0000 + k);
            cyc();
        end
        check("wb_cnt4", dbg_wb_count, 3'd4);
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 10'h310; dc_wdata = 32'hA000_0004;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (dc_done) saw = 1'b1;
        end
        check("wr4_held", saw, 1'b0);
        check("wr4_full_cnt", dbg_wb_count, 3'd4);
        check("drain_state", dbg_state, 2'd3);
        check("drain_head_addr", mem_addr, 10'h300);
        check("drain_head_data", mem_wdata, 32'hA000_0000);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        check("pop_cnt", dbg_wb_count, 3'd3);
        check("wr4_refused_at_ack", dc_done, 1'b0);
        cyc();
        check("wr4_done", dc_done, 1'b1);
        check("wr4_cnt", dbg_wb_count, 3'd4);
        dc_req = 1'b0; dc_we = 1'b0;
        for (int k = 1; k < 5; k++)
            mem_serve($sformatf("dr%0d", k), 1'b1, 10'h300 + 10'(k * 4), 32'hA000_0000 + k, 1, 128'h0);
        check("drained_cnt", dbg_wb_count, 3'd0);
        cyc();

        // --- write and read to the same block arrive together ---
        ic_req = 1'b1; ic_addr = 10'h0A0;
        dc_write("hz_wr", 10'h0AB, 32'hDEAD_BEEF);
        mem_serve("hz_drain", 1'b1, 10'h0A8, 32'hDEAD_BEEF, 1, 128'h0);
        mem_serve("hz_read", 1'b0, 10'h0A0, 32'h0, 2, 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF);
        check("hz_ic_done", ic_done, 1'b1);
        check("hz_ic_rdata", ic_rdata, 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF);
        ic_req = 1'b0;
        cyc();

        // --- reset during a DC read ---
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 10'h150;
        wait_mem_req("rst_rd");
        check("rst_rd_state", dbg_state, 2'd2);
        check("rst_rd_addr", mem_addr, 10'h150);
        cyc();
        rst_n = 1'b0;
        #1;
        check("rst_rd_mem_req", mem_req, 1'b0);
        check("rst_rd_dc_done", dc_done, 1'b0);
        check("rst_rd_state0", dbg_state, 2'd0);
        dc_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (dc_done || mem_req) saw = 1'b1;
        end
        check("rst_rd_quiet", saw, 1'b0);
        check("rst_rd_wb_empty", dbg_wb_count, 3'd0);

        // --- reset with buffered writes ---
        dc_write("rw0", 10'h020, 32'h0000_0020);
        cyc();
        dc_write("rw1", 10'h024, 32'h0000_0024);
        check("rw_cnt2", dbg_wb_count, 3'd2);
        rst_n = 1'b0;
        #1;
        check("rw_rst_cnt", dbg_wb_count, 3'd0);
        check("rw_rst_req", mem_req, 1'b0);
        cyc();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (mem_req || dc_done) saw = 1'b1;
        end
        check("rw_no_drain", saw, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
